// File: rtl/cbus_ram_responder_pkg.sv
// Shared CBus types plus the address-window helper used by the RAM responder.
package cbus_ram_responder_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [3:0]  mlen_t;

  typedef enum logic [2:0] {
    MSIZE_1 = 3'd0,
    MSIZE_2 = 3'd1,
    MSIZE_4 = 3'd2,
    MSIZE_8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  localparam int CBUS_WORD_BYTES = 8;

  // A beat is legal when it lies inside [base, base+span) and a full-word
  // access is naturally aligned.
  function automatic logic addrInRange(input addr_t addr, input msize_t size,
                                       input addr_t base, input addr_t span);
    logic inWindow;
    logic aligned;
    inWindow = (addr >= base) && ((addr - base) < span);
    aligned  = !((size == MSIZE_8) && (addr[2:0] != 3'b000));
    return inWindow && aligned;
  endfunction

endpackage

// File: rtl/cbus_ram_responder_array.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read port.
module cbus_ram_array
  import cbus_ram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  strobe_t          i_strobe,
  input  word_t            i_wdata,
  output word_t            o_rdata
);

  word_t r_mem [DEPTH_WORDS];
  word_t r_rdata;

  // One access per cycle: a write merges the strobed bytes, a read registers the word.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < CBUS_WORD_BYTES; i++) begin
          if (i_strobe[i]) begin
            r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cbus_ram_responder.sv
// CBus responder serving single and FIXED/INCR burst requests from on-chip RAM.
module cbus_ram_responder
  import cbus_ram_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic       busy,
  output logic       range_err
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam addr_t             WINDOW_BYTES = addr_t'(DEPTH_WORDS) << 3;
  localparam logic [WAIT_W-1:0] WAIT_LOAD    = WAIT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic              r_isWrite;
  axi_burst_type_t   r_burst;
  mlen_t             r_len;
  msize_t            r_size;
  addr_t             r_beatAddr;
  logic [WAIT_W-1:0] r_waitCnt;
  mlen_t             r_beatCnt;
  logic              r_rangeErr;

  logic [IDX_W-1:0]  w_index;
  logic [IDX_W-1:0]  w_nextIndex;
  addr_t             w_nextAddr;
  logic              w_inRange;
  logic              w_beat;
  logic              w_ramEn;
  logic              w_ramWe;
  logic [IDX_W-1:0]  w_ramAddr;
  word_t             w_ramRdata;

  // The current beat's word index and legality both follow from its byte address.
  assign w_index     = IDX_W'((r_beatAddr - BASE_ADDR) >> 3);
  assign w_nextIndex = IDX_W'((w_nextAddr - BASE_ADDR) >> 3);
  assign w_inRange   = addrInRange(r_beatAddr, r_size, BASE_ADDR, WINDOW_BYTES);

  // INCR steps one word, wrapping from the top word back to word 0; FIXED stays put.
  always_comb begin
    w_nextAddr = r_beatAddr;
    if (r_burst == BURST_INCR) begin
      if (w_inRange && (w_index == LAST_IDX)) begin
        w_nextAddr = BASE_ADDR | {61'b0, r_beatAddr[2:0]};
      end else begin
        w_nextAddr = r_beatAddr + 64'd8;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state, bus response and RAM port control.
  always_comb begin
    w_stateNext = r_state;
    resp        = '0;
    w_beat      = 1'b0;
    w_ramEn     = 1'b0;
    w_ramWe     = 1'b0;
    w_ramAddr   = w_index;
    unique case (r_state)
      IDLE: begin
        if (req.valid) begin
          w_stateNext = WAIT;
        end
      end
      WAIT: begin
        if (!req.valid) begin
          w_stateNext = IDLE;
        end else if (r_waitCnt == '0) begin
          w_stateNext = BURST;
          w_ramEn     = !r_isWrite;
        end
      end
      BURST: begin
        if (!req.valid) begin
          w_stateNext = IDLE;
        end else begin
          w_beat     = 1'b1;
          resp.ready = 1'b1;
          resp.last  = (r_beatCnt == r_len);
          if (r_isWrite) begin
            w_ramEn = w_inRange;
            w_ramWe = 1'b1;
          end else begin
            resp.data = w_inRange ? w_ramRdata : '0;
            w_ramEn   = 1'b1;
            w_ramAddr = w_nextIndex;
          end
          if (r_beatCnt == r_len) begin
            w_stateNext = DONE;
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Request capture, latency and beat counters, address advance and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_isWrite  <= 1'b0;
      r_burst    <= BURST_FIXED;
      r_len      <= '0;
      r_size     <= MSIZE_1;
      r_beatAddr <= '0;
      r_waitCnt  <= '0;
      r_beatCnt  <= '0;
      r_rangeErr <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req.valid) begin
            r_isWrite  <= req.is_write;
            r_burst    <= req.burst;
            r_len      <= req.len;
            r_size     <= req.size;
            r_beatAddr <= req.addr;
            r_waitCnt  <= WAIT_LOAD;
            r_beatCnt  <= '0;
          end
        end
        WAIT: begin
          if (req.valid && (r_waitCnt != '0)) begin
            r_waitCnt <= r_waitCnt - WAIT_W'(1);
          end
        end
        BURST: begin
          if (w_beat) begin
            r_beatCnt  <= r_beatCnt + mlen_t'(1);
            r_beatAddr <= w_nextAddr;
            if (!w_inRange) begin
              r_rangeErr <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  cbus_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_ramEn),
    .i_we    (w_ramWe),
    .i_addr  (w_ramAddr),
    .i_strobe(req.strobe),
    .i_wdata (req.data),
    .o_rdata (w_ramRdata)
  );

  assign busy      = (r_state != IDLE);
  assign range_err = r_rangeErr;

endmodule

// File: tb/tb_cbus_ram_responder.sv
// Directed bench for the CBus RAM responder with hand-computed expectations.
module tb_cbus_ram_responder;
  import cbus_ram_responder_pkg::*;

  logic       clk;
  logic       reset;
  cbus_req_t  req;
  cbus_resp_t resp;
  logic       busy;
  logic       rangeErr;

  int    errors = 0;
  int    checks = 0;
  word_t wrData [16];
  word_t rdData [16];
  logic  lastSeen [16];
  int    beatsSeen;
  int    firstBeatCycle;

  cbus_ram_responder #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (64'h8000_0000),
    .LATENCY    (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .resp     (resp),
    .busy     (busy),
    .range_err(rangeErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a transfer never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction starting #1 after a posedge; returns in the DONE cycle,
  // or in the abort cycle when dropAt beats have completed.
  task automatic applyStimulus(input logic isWr, input addr_t a, input mlen_t ln,
                               input axi_burst_type_t bt, input strobe_t sb,
                               input int dropAt);
    int   cyc;
    int   beat;
    logic done;
    cyc = 0;
    beat = 0;
    done = 1'b0;
    beatsSeen = 0;
    firstBeatCycle = -1;
    for (int k = 0; k < 16; k++) begin
      rdData[k]   = '0;
      lastSeen[k] = 1'b0;
    end
    req.valid    = 1'b1;
    req.is_write = isWr;
    req.size     = MSIZE_8;
    req.addr     = a;
    req.strobe   = sb;
    req.data     = wrData[0];
    req.len      = ln;
    req.burst    = bt;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (resp.ready && beat < 16) begin
        rdData[beat]   = resp.data;
        lastSeen[beat] = resp.last;
        if (beat == 0) firstBeatCycle = cyc;
        if (resp.last) done = 1'b1;
        beat++;
        beatsSeen = beat;
      end
      nextCycle();
      cyc++;
      if (beat < 16) req.data = wrData[beat];
      if (beat == dropAt) done = 1'b1;
      if (done) req.valid = 1'b0;
    end
    req.valid = 1'b0;
  endtask

  // Checks the quiet DONE cycle and steps into IDLE.
  task automatic checkDone(input string tag);
    @(negedge clk);
    checkOutput({tag, "_doneReady"}, 64'(resp.ready), 64'd0);
    checkOutput({tag, "_doneBusy"}, 64'(busy), 64'd1);
    nextCycle();
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    for (int k = 0; k < 16; k++) wrData[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstReady", 64'(resp.ready), 64'd0);
    checkOutput("rstLast", 64'(resp.last), 64'd0);
    checkOutput("rstData", resp.data, 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstRangeErr", 64'(rangeErr), 64'd0);
    reset = 1'b1;
    nextCycle();

    $display("[TB] single write then read");
    wrData[0] = 64'h1122_3344_5566_7788;
    applyStimulus(1'b1, 64'h8000_0010, 4'd0, BURST_INCR, 8'hFF, -1);
    checkOutput("wr1Latency", 64'(firstBeatCycle), 64'd3);
    checkOutput("wr1Beats", 64'(beatsSeen), 64'd1);
    checkOutput("wr1Last", 64'(lastSeen[0]), 64'd1);
    checkOutput("wr1Data", rdData[0], 64'd0);
    checkDone("wr1");
    applyStimulus(1'b0, 64'h8000_0010, 4'd0, BURST_INCR, 8'h00, -1);
    checkOutput("rd1Latency", 64'(firstBeatCycle), 64'd3);
    checkOutput("rd1Data", rdData[0], 64'h1122_3344_5566_7788);
    checkOutput("rd1Last", 64'(lastSeen[0]), 64'd1);
    checkDone("rd1");

    $display("[TB] strobed write");
    wrData[0] = 64'hAAAA_AAAA_BBBB_BBBB;
    applyStimulus(1'b1, 64'h8000_0010, 4'd0, BURST_INCR, 8'h0F, -1);
    checkDone("wr2");
    applyStimulus(1'b0, 64'h8000_0010, 4'd0, BURST_INCR, 8'h00, -1);
    checkOutput("rd2Data", rdData[0], 64'h1122_3344_BBBB_BBBB);
    checkDone("rd2");

    $display("[TB] INCR preload and INCR read");
    for (int k = 0; k < 4; k++) wrData[k] = 64'(k);
    applyStimulus(1'b1, 64'h8000_0000, 4'd3, BURST_INCR, 8'hFF, -1);
    checkOutput("wr3Beats", 64'(beatsSeen), 64'd4);
    checkDone("wr3");
    applyStimulus(1'b0, 64'h8000_0000, 4'd3, BURST_INCR, 8'h00, -1);
    checkOutput("rd3Beats", 64'(beatsSeen), 64'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rd3Data%0d", k), rdData[k], 64'(k));
      checkOutput($sformatf("rd3Last%0d", k), 64'(lastSeen[k]), (k == 3) ? 64'd1 : 64'd0);
    end
    checkDone("rd3");

    $display("[TB] FIXED write");
    for (int k = 0; k < 4; k++) wrData[k] = 64'(k + 5);
    applyStimulus(1'b1, 64'h8000_0000, 4'd3, BURST_FIXED, 8'hFF, -1);
    checkOutput("wr4Beats", 64'(beatsSeen), 64'd4);
    checkDone("wr4");
    applyStimulus(1'b0, 64'h8000_0000, 4'd1, BURST_INCR, 8'h00, -1);
    checkOutput("rd4Word0", rdData[0], 64'd8);
    checkOutput("rd4Word1", rdData[1], 64'd1);
    checkDone("rd4");

    $display("[TB] INCR wrap at top word");
    wrData[0] = 64'h0000_0000_0000_DEAD;
    applyStimulus(1'b1, 64'h8000_7FF8, 4'd0, BURST_INCR, 8'hFF, -1);
    checkDone("wr5");
    applyStimulus(1'b0, 64'h8000_7FF8, 4'd1, BURST_INCR, 8'h00, -1);
    checkOutput("rd5Top", rdData[0], 64'h0000_0000_0000_DEAD);
    checkOutput("rd5Wrap", rdData[1], 64'd8);
    checkOutput("rd5Last", 64'(lastSeen[1]), 64'd1);
    checkDone("rd5");
    checkOutput("rangeErrClean", 64'(rangeErr), 64'd0);

    $display("[TB] out-of-range read");
    applyStimulus(1'b0, 64'h7FFF_FFF8, 4'd0, BURST_INCR, 8'h00, -1);
    checkOutput("oorData", rdData[0], 64'd0);
    checkOutput("oorLast", 64'(lastSeen[0]), 64'd1);
    checkDone("oor");
    checkOutput("oorRangeErr", 64'(rangeErr), 64'd1);

    $display("[TB] abort on second write beat");
    wrData[0] = 64'h99;
    applyStimulus(1'b1, 64'h8000_0048, 4'd0, BURST_INCR, 8'hFF, -1);
    checkDone("wr6");
    wrData[0] = 64'h11;
    wrData[1] = 64'h22;
    wrData[2] = 64'h33;
    wrData[3] = 64'h44;
    applyStimulus(1'b1, 64'h8000_0040, 4'd3, BURST_INCR, 8'hFF, 1);
    @(negedge clk);
    checkOutput("abortReady", 64'(resp.ready), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 64'h8000_0040, 4'd1, BURST_INCR, 8'h00, -1);
    checkOutput("abortWord8", rdData[0], 64'h11);
    checkOutput("abortWord9", rdData[1], 64'h99);
    checkDone("rd7");
    checkOutput("rangeErrSticky", 64'(rangeErr), 64'd1);

    $display("[TB] reset during WAIT");
    req.valid    = 1'b1;
    req.is_write = 1'b0;
    req.size     = MSIZE_8;
    req.addr     = 64'h8000_0040;
    req.strobe   = 8'h00;
    req.data     = '0;
    req.len      = 4'd0;
    req.burst    = BURST_INCR;
    nextCycle();
    @(negedge clk);
    checkOutput("waitBusy", 64'(busy), 64'd1);
    reset = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("midRstReady", 64'(resp.ready), 64'd0);
    checkOutput("midRstData", resp.data, 64'd0);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstRangeErr", 64'(rangeErr), 64'd0);
    req.valid = 1'b0;
    reset = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 64'h8000_0040, 4'd0, BURST_INCR, 8'h00, -1);
    checkOutput("postRstData", rdData[0], 64'h11);
    checkDone("rd8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
